spi_deserializer: RTL and testbench

Receive side of the team's SPI link: oversamples an externally driven `sclk`/`mosi` pair in the `clk` domain, assembles MSB-first words of `DATAWIDTH` bits, and pushes each completed word into a downstream write-side FIFO through a write-enable/full handshake. It pairs with the SPI serializer in the same design. That serializer drives `mosi` before the falling edge of `sclk`, and this block samples on the rising edge. One holding register decouples word completion from FIFO backpressure; when that register is already occupied, further words are dropped and flagged as overflow.

---
 rtl/spi_deserializer.sv | 82 ++++++++
 tb/tb_spi_deserializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_deserializer.sv
// spi_deserializer: oversampled SPI receive path, MSB-first words into a write-side FIFO
// Ports: clk/rst (async, active-high); sclk_in, mosi_in (and cs_n_in with
// SPI_DESER_CS_EN) serial inputs; clear flushes partial/held word and overflow;
// full is FIFO backpressure; write_en/write_data push a word; busy marks a
// partial word; overflow is sticky on a dropped word.
module spi_deserializer #(
  parameter int DATAWIDTH = 32,
  parameter int BITCOUNTERWIDTH = $clog2(DATAWIDTH) + 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk_in,
  input  logic                 mosi_in,
`ifdef SPI_DESER_CS_EN
  input  logic                 cs_n_in,
`endif
  input  logic                 clear,
  input  logic                 full,
  output logic                 write_en,
  output logic [DATAWIDTH-1:0] write_data,
  output logic                 busy,
  output logic                 overflow
);
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync;
  logic sclk_d, cs_n_s, rise, last, done, hold_valid;
  logic [BITCOUNTERWIDTH-1:0] bit_counter;
  logic [DATAWIDTH-1:0] shift_reg, hold_reg;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_d <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      sclk_d <= sclk_sync[SYNC_STAGES-1];
    end
`ifdef SPI_DESER_CS_EN
  logic [SYNC_STAGES-1:0] cs_sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) cs_sync <= '0;
    else cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs_n_in};
  assign cs_n_s = cs_sync[SYNC_STAGES-1];
`else
  assign cs_n_s = 1'b0;
`endif
  assign rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d & ~cs_n_s;
  assign last = bit_counter == BITCOUNTERWIDTH'(DATAWIDTH - 1);
  assign busy = bit_counter != '0;
  assign write_en = hold_valid & ~full;
  assign write_data = hold_reg;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bit_counter <= '0;
      shift_reg <= '0;
    end else if (clear || cs_n_s) begin
      bit_counter <= '0;
      shift_reg <= '0;
    end else if (rise) begin
      shift_reg <= {shift_reg[DATAWIDTH-2:0], mosi_sync[SYNC_STAGES-1]};
      bit_counter <= last ? '0 : bit_counter + 1'b1;
    end
  // done marks the completion cycle; shift_reg is stable then since the next
  // sclk rise is at least four cycles away
  always_ff @(posedge clk or posedge rst)
    if (rst) done <= 1'b0;
    else done <= ~clear & rise & last;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_reg <= '0;
      hold_valid <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      hold_valid <= 1'b0;
      overflow <= 1'b0;
    end else if (done && hold_valid && !write_en) overflow <= 1'b1;
    else if (done) begin
      hold_reg <= shift_reg;
      hold_valid <= 1'b1;
    end else if (write_en) hold_valid <= 1'b0;
endmodule

// File: tb/tb_spi_deserializer.sv
// tb_spi_deserializer: randomized self-checking bench for spi_deserializer
module tb_spi_deserializer;
  localparam int W = 32;
  logic clk = 0, rst = 1, sclk_in = 0, mosi_in = 0, clear = 0, full = 0;
`ifdef SPI_DESER_CS_EN
  logic cs_n_in = 0;
`endif
  logic write_en, busy, overflow;
  logic [W-1:0] write_data;
  int checks = 0, failures = 0, cyc = 0, last_rise = 0;
  logic [W-1:0] wq[$];
  int wc[$];
  spi_deserializer #(.DATAWIDTH(W)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .mosi_in(mosi_in),
`ifdef SPI_DESER_CS_EN
    .cs_n_in(cs_n_in),
`endif
    .clear(clear), .full(full), .write_en(write_en), .write_data(write_data),
    .busy(busy), .overflow(overflow));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (write_en) begin
      wq.push_back(write_data);
      wc.push_back(cyc);
    end
  task tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task send_bits(input logic [W-1:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      sclk_in = 0;
      mosi_in = w[i];
      tick(2);
      sclk_in = 1;
      last_rise = cyc;
      tick(2);
    end
  endtask
  task check_outputs_zero(input string tag);
    checks++;
    if (write_en !== 1'b0 || write_data !== '0 || busy !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL %s: write_en=%b write_data=%h busy=%b overflow=%b, required all 0",
               tag, write_en, write_data, busy, overflow);
    end
  endtask
  task test_reset;
    for (int i = 0; i < 4; i++) begin
      sclk_in = 1'($urandom);
      mosi_in = 1'($urandom);
      tick();
    end
    check_outputs_zero("reset");
    sclk_in = 0;
    rst = 0;
    tick(4);
    check_outputs_zero("post_reset");
  endtask
  task test_single;
    logic [W-1:0] w = 32'hA5C3_0F96;
    wq.delete(); wc.delete();
    send_bits(w, 31, 27);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_mid: got %b want 1", busy); end
    send_bits(w, 26, 0);
    tick(6);
    checks++;
    if (wq.size() != 1) begin failures++; $display("FAIL single_count: got %0d want 1", wq.size()); end
    else begin
      checks++;
      if (wq[0] !== w) begin failures++; $display("FAIL single_data: got %h want %h", wq[0], w); end
      checks++;
      if (wc[0] != last_rise + 4) begin failures++; $display("FAIL single_latency: got %0d want %0d", wc[0] - last_rise, 4); end
    end
    checks++;
    if (busy !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL single_idle: busy=%b overflow=%b want 0 0", busy, overflow); end
  endtask
  task test_backpressure;
    logic [W-1:0] w = 32'h1234_5678;
    int rel;
    wq.delete(); wc.delete();
    full = 1;
    send_bits(w, 31, 0);
    tick(12);
    checks++;
    if (wq.size() != 0) begin failures++; $display("FAIL bp_hold: got %0d writes want 0", wq.size()); end
    full = 0;
    rel = cyc;
    tick(4);
    checks++;
    if (wq.size() != 1 || wq[0] !== w || wc[0] != rel) begin
      failures++;
      $display("FAIL bp_release: writes=%0d data=%h cyc=%0d, want 1 %h %0d", wq.size(),
               wq.size() ? wq[0] : '0, wc.size() ? wc[0] : -1, w, rel);
    end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL bp_overflow: got %b want 0", overflow); end
  endtask
  task test_overflow;
    wq.delete(); wc.delete();
    full = 1;
    send_bits(32'h1111_1111, 31, 0);
    send_bits(32'h2222_2222, 31, 0);
    tick(4);
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", overflow); end
    full = 0;
    tick(4);
    checks++;
    if (wq.size() != 1 || wq[0] !== 32'h1111_1111) begin
      failures++;
      $display("FAIL ovf_writes: count=%0d first=%h want 1 11111111", wq.size(), wq.size() ? wq[0] : '0);
    end
    clear = 1;
    tick();
    clear = 0;
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask
  task test_simultaneous;
    wq.delete(); wc.delete();
    full = 1;
    send_bits(32'h1111_1111, 31, 0);
    send_bits(32'h2222_2222, 31, 0);
    tick();
    full = 0;
    tick(5);
    checks++;
    if (wq.size() != 2 || wq[0] !== 32'h1111_1111 || wq[1] !== 32'h2222_2222 || wc[1] != wc[0] + 1) begin
      failures++;
      $display("FAIL simul_writes: count=%0d d0=%h d1=%h want 2 11111111 22222222 consecutive",
               wq.size(), wq.size() > 0 ? wq[0] : '0, wq.size() > 1 ? wq[1] : '0);
    end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL simul_overflow: got %b want 0", overflow); end
  endtask
  task test_random_stream;
    logic [W-1:0] model[$];
    wq.delete(); wc.delete();
    for (int i = 0; i < 6; i++) begin
      model.push_back($urandom);
      send_bits(model[i], 31, 0);
    end
    tick(6);
    checks++;
    if (wq.size() != model.size()) begin failures++; $display("FAIL rand_count: got %0d want %0d", wq.size(), model.size()); end
    else
      for (int i = 0; i < model.size(); i++) begin
        checks++;
        if (wq[i] !== model[i]) begin failures++; $display("FAIL rand_data[%0d]: got %h want %h", i, wq[i], model[i]); end
      end
  endtask
  task test_random_groups;
    for (int g = 0; g < 3; g++) begin
      int k = $urandom_range(1, 3);
      logic [W-1:0] first = $urandom;
      wq.delete(); wc.delete();
      full = 1;
      send_bits(first, 31, 0);
      for (int i = 1; i < k; i++) send_bits($urandom, 31, 0);
      tick(4);
      checks++;
      if (overflow !== (k >= 2)) begin failures++; $display("FAIL grp%0d_overflow k=%0d: got %b want %b", g, k, overflow, k >= 2); end
      full = 0;
      tick(4);
      checks++;
      if (wq.size() != 1 || wq[0] !== first) begin
        failures++;
        $display("FAIL grp%0d_writes: count=%0d data=%h want 1 %h", g, wq.size(), wq.size() ? wq[0] : '0, first);
      end
      clear = 1;
      tick();
      clear = 0;
    end
  endtask
  task test_reset_mid_word;
    send_bits($urandom, 31, 19);
    rst = 1;
    sclk_in = 0;
    #1;
    check_outputs_zero("rst_mid_async");
    tick(3);
    check_outputs_zero("rst_mid_hold");
    rst = 0;
    tick(3);
    wq.delete(); wc.delete();
    send_bits(32'hDEAD_BEEF, 31, 0);
    tick(6);
    checks++;
    if (wq.size() != 1 || wq[0] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rst_mid_write: count=%0d data=%h want 1 deadbeef", wq.size(), wq.size() ? wq[0] : '0);
    end
  endtask
`ifdef SPI_DESER_CS_EN
  task test_frame_abort;
    wq.delete(); wc.delete();
    send_bits($urandom, 31, 25);
    cs_n_in = 1;
    tick(4);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL cs_busy: got %b want 0", busy); end
    sclk_in = 0;
    cs_n_in = 0;
    tick(4);
    send_bits(32'hCAFE_F00D, 31, 0);
    tick(6);
    checks++;
    if (wq.size() != 1 || wq[0] !== 32'hCAFE_F00D || overflow !== 1'b0) begin
      failures++;
      $display("FAIL cs_write: count=%0d data=%h overflow=%b want 1 cafef00d 0",
               wq.size(), wq.size() ? wq[0] : '0, overflow);
    end
  endtask
`endif
  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_overflow;
    test_simultaneous;
    test_random_stream;
    test_random_groups;
    test_reset_mid_word;
`ifdef SPI_DESER_CS_EN
    test_frame_abort;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
